// File: rtl/bit_serial_adder_ctrl_pkg.sv
`default_nettype none
// ===================================================================
// serial_arith_pkg : shared state encodings and sizing helpers
// Rev 1.0
// ===================================================================
package serial_arith_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int cnt_width(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage
`default_nettype wire

// File: rtl/bit_serial_adder_ctrl_if.sv
`default_nettype none
// ===================================================================
// bit_serial_adder_ctrl_if : requester <-> serial adder handshake
// Rev 1.0
// ===================================================================
interface bit_serial_adder_ctrl_if
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             carry_out;
   logic             overflow;

   modport master (
      output start, sub, op_a, op_b,
      input  busy, done, result, carry_out, overflow
   );

   modport slave (
      input  start, sub, op_a, op_b,
      output busy, done, result, carry_out, overflow
   );
endinterface
`default_nettype wire

// File: rtl/bit_serial_adder_ctrl_famux.sv
`default_nettype none
// ===================================================================
// famux : mux-based full-adder cell (a, b, c -> sum, cy)
// Rev 1.0
// ===================================================================
module famux (
   input  wire logic a,
   input  wire logic b,
   input  wire logic c,
   output logic      sum,
   output logic      cy
);
   logic w_p;

   always_comb begin
      w_p = a ^ b;
      sum = c ? ~w_p : w_p;
      // propagate passes the incoming carry; otherwise a==b is the generate/kill value
      cy  = w_p ? c : a;
   end
endmodule
`default_nettype wire

// File: rtl/bit_serial_adder_ctrl.sv
`default_nettype none
// ===================================================================
// bit_serial_adder_ctrl : LSB-first add/subtract over one shared FA cell
// Rev 1.0
// ===================================================================
module bit_serial_adder_ctrl
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  wire logic               clk,
   input  wire logic               rst_n,
   bit_serial_adder_ctrl_if.slave  bus
);
   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sh_a_q, sh_a_d;
   logic [WIDTH-1:0] sh_b_q, sh_b_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             carry_out_q, carry_out_d;
   logic             overflow_q, overflow_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             fa_sum;
   logic             fa_cy;

   famux u_famux (
      .a   (sh_a_q[0]),
      .b   (sh_b_q[0]),
      .c   (carry_q),
      .sum (fa_sum),
      .cy  (fa_cy)
   );

   always_comb begin
      state_d     = state_q;
      sh_a_d      = sh_a_q;
      sh_b_d      = sh_b_q;
      result_d    = result_q;
      cnt_d       = cnt_q;
      carry_d     = carry_q;
      carry_out_d = carry_out_q;
      overflow_d  = overflow_q;
      busy_d      = busy_q;
      done_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               // subtraction is a + ~b + 1: invert B and seed the carry with 1
               sh_a_d      = bus.op_a;
               sh_b_d      = bus.op_b ^ {WIDTH{bus.sub}};
               carry_d     = bus.sub;
               cnt_d       = '0;
               result_d    = '0;
               carry_out_d = 1'b0;
               overflow_d  = 1'b0;
               busy_d      = 1'b1;
               state_d     = RUN;
            end
         end
         RUN: begin
            result_d = {fa_sum, result_q[WIDTH-1:1]};
            sh_a_d   = sh_a_q >> 1;
            sh_b_d   = sh_b_q >> 1;
            carry_d  = fa_cy;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) begin
               // carry_q here is the carry into the MSB
               carry_out_d = fa_cy;
               overflow_d  = carry_q ^ fa_cy;
               done_d      = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         sh_a_q      <= '0;
         sh_b_q      <= '0;
         result_q    <= '0;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sh_a_q      <= sh_a_d;
         sh_b_q      <= sh_b_d;
         result_q    <= result_d;
         cnt_q       <= cnt_d;
         carry_q     <= carry_d;
         carry_out_q <= carry_out_d;
         overflow_q  <= overflow_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.result    = result_q;
   assign bus.carry_out = carry_out_q;
   assign bus.overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_bit_serial_adder_ctrl.sv
`default_nettype none
// ===================================================================
// tb_bit_serial_adder_ctrl : vector table + scoreboard bench, WIDTH=8
// Rev 1.0
// ===================================================================
module tb_bit_serial_adder_ctrl;
   localparam int W = 8;

   typedef struct {
      logic         sub;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] r;
      logic         co;
      logic         ov;
   } vec_t;

   typedef struct {
      logic [W-1:0] r;
      logic         co;
      logic         ov;
      int           cyc;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   tests_run;
   int   tests_failed;
   exp_t sb[$];
   vec_t tbl[8];

   bit_serial_adder_ctrl_if #(.WIDTH(W)) bus ();

   bit_serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
      $fatal(1);
   end

   // Independent reference: wide sum plus sign-rule overflow.
   function automatic exp_t model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t     e;
      logic [W:0] full;
      if (s) full = {1'b0, a} + {1'b0, ~b} + 1;
      else   full = {1'b0, a} + {1'b0, b};
      e.r  = full[W-1:0];
      e.co = full[W];
      if (s) e.ov = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]);
      else   e.ov = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
      e.cyc = 0;
      return e;
   endfunction

   // Scoreboard: every done must match the head entry in value and cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         if (sb.size() > 0 && cyc > sb[0].cyc) begin
            tests_run++;
            tests_failed++;
            $display("FAIL missing_done: no done by cycle %0d, required at cycle %0d", cyc, sb[0].cyc);
            void'(sb.pop_front());
         end
         if (bus.done) begin
            tests_run++;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
               if (bus.result !== sb[0].r || bus.carry_out !== sb[0].co || bus.overflow !== sb[0].ov) begin
                  tests_failed++;
                  $display("FAIL op_result cycle %0d: got r=%h co=%b ov=%b, required r=%h co=%b ov=%b",
                           cyc, bus.result, bus.carry_out, bus.overflow, sb[0].r, sb[0].co, sb[0].ov);
               end
               void'(sb.pop_front());
            end else begin
               tests_failed++;
               $display("FAIL unexpected_done at cycle %0d: got done=1, required done=0 (pending=%0d)",
                        cyc, sb.size());
            end
         end
      end
   end

   task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] r, input logic co, input logic ov);
      exp_t e;
      bus.start = 1'b1;
      bus.sub   = s;
      bus.op_a  = a;
      bus.op_b  = b;
      e.r = r; e.co = co; e.ov = ov; e.cyc = cyc + W + 1;
      sb.push_back(e);
   endtask

   // Single op; operands scrambled after acceptance must not matter.
   task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] r, input logic co, input logic ov);
      @(negedge clk);
      issue(s, a, b, r, co, ov);
      @(negedge clk);
      bus.start = 1'b0;
      bus.sub   = ~s;
      bus.op_a  = W'($urandom);
      bus.op_b  = W'($urandom);
      repeat (W) @(negedge clk);
   endtask

   task automatic check_zero(input string name);
      tests_run++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== '0 ||
          bus.carry_out !== 1'b0 || bus.overflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL %s: got busy=%b done=%b r=%h co=%b ov=%b, required all zero",
                  name, bus.busy, bus.done, bus.result, bus.carry_out, bus.overflow);
      end
   endtask

   initial begin
      exp_t e;
      int   base;
      logic [W-1:0] ra, rb;
      logic rs;

      tests_run    = 0;
      tests_failed = 0;
      tbl[0] = '{1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1};
      tbl[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
      tbl[2] = '{1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0};
      tbl[3] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
      tbl[4] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
      tbl[5] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
      tbl[6] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
      tbl[7] = '{1'b1, 8'h55, 8'h55, 8'h00, 1'b1, 1'b0};

      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.sub   = 1'b0;
      bus.op_a  = '0;
      bus.op_b  = '0;
      repeat (2) @(negedge clk);
      check_zero("reset_state");
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++)
         run_op(tbl[i].sub, tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].co, tbl[i].ov);

      // start re-pulsed during RUN and across DONE must be ignored
      @(negedge clk);
      base = cyc;
      issue(1'b0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0);
      @(negedge clk); bus.start = 1'b0;
      @(negedge clk); bus.start = 1'b1; bus.op_a = 8'hFF;
      @(negedge clk); bus.start = 1'b0;
      repeat (5) @(negedge clk);
      bus.start = 1'b1; bus.op_a = 8'hFF;
      repeat (2) @(negedge clk);
      bus.start = 1'b0;
      tests_run++;
      if (bus.busy !== 1'b0 || cyc != base + W + 2) begin
         tests_failed++;
         $display("FAIL busy_after_done: got busy=%b at cycle %0d, required busy=0 at cycle %0d",
                  bus.busy, cyc, base + W + 2);
      end
      repeat (W + 2) @(negedge clk);

      // asynchronous reset in the middle of RUN
      @(negedge clk);
      issue(1'b0, 8'h33, 8'h44, 8'h77, 1'b0, 1'b0);
      @(negedge clk); bus.start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_zero("async_reset_mid_run");
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (W + 2) @(negedge clk);
      run_op(1'b1, 8'h33, 8'h44, 8'hEF, 1'b0, 1'b0);

      // start held high: three back-to-back ops, done every W+2 cycles
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
         e = model(rs, ra, rb);
         issue(rs, ra, rb, e.r, e.co, e.ov);
         repeat (W + 1) @(negedge clk);
      end
      bus.start = 1'b0;
      repeat (3) @(negedge clk);

      for (int n = 0; n < 1000; n++) begin
         ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
         e = model(rs, ra, rb);
         run_op(rs, ra, rb, e.r, e.co, e.ov);
      end

      repeat (3) @(negedge clk);
      tests_run++;
      if (sb.size() != 0) begin
         tests_failed++;
         $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
`default_nettype wire
